knight_rider_scanner: RTL and testbench

Parametrised successor to the board-level Knight Rider flasher, generalised to N LEDs. It integrates the on/off toggle, a programmable step-rate divider and an up/down position counter in one clocked block. It adds four display modes and a runtime speed select, and drives the LEDR bank directly. It sits between the board clock / push-button inputs and the LED pins.

---
 rtl/knight_rider_scanner.sv | 132 +++++++++++++
 tb/tb_knight_rider_scanner.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knight_rider_scanner.sv
// N-LED Knight Rider scanner: on/off toggle, step-rate divider,
// up/down position counter and four LED display modes.
module knight_rider_scanner #(
  parameter int N_LEDS = 10,
  parameter int DIV    = 5555555,
  parameter int CNT_W  = 24,
  parameter int POS_W  = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              ONOFF_N,
  input  logic [1:0]        MODE,
  input  logic [1:0]        SPEED,
  output logic [N_LEDS-1:0] LEDR,
  output logic [POS_W-1:0]  POS,
  output logic              DIR,
  output logic              RUN,
  output logic              STEP
);

  localparam logic [1:0] M_WRAP = 2'b01;
  localparam logic [1:0] M_BAR  = 2'b10;
  localparam logic [1:0] M_MIR  = 2'b11;

  localparam logic [CNT_W-1:0] PRE_TOP = CNT_W'(DIV - 1);
  localparam logic [POS_W-1:0] POS_TOP = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_PEN = POS_W'(N_LEDS - 2);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic             s1, s2, s3;
  logic             fall, tog;
  logic [CNT_W-1:0] presc;
  logic [1:0]       sub;
  logic             tick, fire;
  logic [POS_W-1:0] pos_nxt;
  logic             dir_nxt;

  // two sync flops plus one history flop for falling-edge detection
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      s3  <= 1'b1;
      tog <= 1'b0;
    end else begin
      s1  <= ONOFF_N;
      s2  <= s1;
      s3  <= s2;
      tog <= fall;
    end
  end

  assign fall = ~s2 & s3;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      RUN <= 1'b0;
    else if (tog)
      RUN <= ~RUN;
  end

  assign tick = (presc == PRE_TOP);
  // >= so that lowering SPEED below sub never stalls the scan
  assign fire = RUN & tick & (sub >= SPEED);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      presc <= '0;
      sub   <= '0;
    end else if (!RUN) begin
      presc <= '0;
      sub   <= '0;
    end else if (tick) begin
      presc <= '0;
      sub   <= fire ? 2'd0 : sub + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    pos_nxt = POS;
    dir_nxt = DIR;
    if (MODE == M_WRAP) begin
      dir_nxt = 1'b0;
      pos_nxt = (POS == POS_TOP) ? '0 : POS + 1'b1;
    end else if (!DIR) begin
      if (POS == POS_TOP) begin
        dir_nxt = 1'b1;
        pos_nxt = POS_PEN;
      end else begin
        pos_nxt = POS + 1'b1;
      end
    end else begin
      if (POS == '0) begin
        dir_nxt = 1'b0;
        pos_nxt = POS_ONE;
      end else begin
        pos_nxt = POS - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      POS  <= '0;
      DIR  <= 1'b0;
      STEP <= 1'b0;
    end else begin
      STEP <= fire;
      if (fire) begin
        POS <= pos_nxt;
        DIR <= dir_nxt;
      end
    end
  end

  always_comb begin
    LEDR = '0;
    if (RUN) begin
      for (int i = 0; i < N_LEDS; i++) begin
        case (MODE)
          M_BAR:   LEDR[i] = (i <= int'(POS));
          M_MIR:   LEDR[i] = (i == int'(POS)) ||
                             (i == N_LEDS - 1 - int'(POS));
          default: LEDR[i] = (i == int'(POS));
        endcase
      end
    end
  end

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Bench for knight_rider_scanner: behavioural model compared every
// cycle, directed scenarios with literal expectations, random stimulus.
module tb_knight_rider_scanner;

  localparam int N  = 10;
  localparam int DV = 4;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       ONOFF_N = 1'b1;
  logic [1:0] MODE = 2'b00;
  logic [1:0] SPEED = 2'b00;

  logic [9:0] LEDR;
  logic [3:0] POS;
  logic       DIR, RUN, STEP;

  logic [8:0] LEDR9;
  logic [3:0] POS9;
  logic       DIR9, RUN9, STEP9;

  int checks = 0;
  int errors = 0;

  knight_rider_scanner #(
    .N_LEDS(10), .DIV(4), .CNT_W(3), .POS_W(4)
  ) dut (
    .CLK(CLK), .CLR(CLR), .ONOFF_N(ONOFF_N),
    .MODE(MODE), .SPEED(SPEED),
    .LEDR(LEDR), .POS(POS), .DIR(DIR),
    .RUN(RUN), .STEP(STEP)
  );

  knight_rider_scanner #(
    .N_LEDS(9), .DIV(1), .CNT_W(1), .POS_W(4)
  ) dut9 (
    .CLK(CLK), .CLR(CLR), .ONOFF_N(ONOFF_N),
    .MODE(MODE), .SPEED(SPEED),
    .LEDR(LEDR9), .POS(POS9), .DIR(DIR9),
    .RUN(RUN9), .STEP(STEP9)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // expected LED pattern from position/mode using plain bit arithmetic
  function automatic logic [63:0] led_of(input int n, input int p,
                                         input logic [1:0] m,
                                         input logic r);
    logic [63:0] one;
    one = 64'd1;
    if (!r) return '0;
    case (m)
      2'b10:   return (one << (p + 1)) - one;
      2'b11:   return (one << p) | (one << (n - 1 - p));
      default: return one << p;
    endcase
  endfunction

  // behavioural model of the 10-LED instance
  int  mcyc, mtick, mpos;
  bit  mdir, mrun, mstep;
  bit  hist [4];

  always @(posedge CLK) begin
    bit tgl, stp;
    logic [63:0] e10, e9;
    logic [9:0]  x10;
    logic [8:0]  x9;
    if (CLR) begin
      mcyc = 0; mtick = 0; mpos = 0;
      mdir = 0; mrun = 0; mstep = 0;
      for (int i = 0; i < 4; i++) hist[i] = 1'b1;
    end else begin
      tgl = (hist[2] == 1'b0) && (hist[3] == 1'b1);
      stp = mrun && (mcyc == DV - 1) && (mtick >= int'(SPEED));
      if (!mrun) begin
        mcyc = 0; mtick = 0;
      end else if (mcyc == DV - 1) begin
        mcyc = 0;
        mtick = stp ? 0 : mtick + 1;
      end else begin
        mcyc++;
      end
      if (stp) begin
        if (MODE == 2'b01) begin
          mdir = 0;
          mpos = (mpos + 1) % N;
        end else if (!mdir) begin
          if (mpos == N - 1) begin mdir = 1; mpos = N - 2; end
          else mpos++;
        end else begin
          if (mpos == 0) begin mdir = 0; mpos = 1; end
          else mpos--;
        end
      end
      mstep = stp;
      if (tgl) mrun = !mrun;
      hist[3] = hist[2]; hist[2] = hist[1];
      hist[1] = hist[0]; hist[0] = ONOFF_N;
    end
    #1;
    chk("run", RUN, mrun);
    chk("pos", POS, mpos);
    chk("dir", DIR, mdir);
    chk("step", STEP, mstep);
    e10 = led_of(N, mpos, MODE, mrun);
    x10 = e10[9:0];
    chk("ledr", LEDR, x10);
    e9 = led_of(9, int'(POS9), MODE, RUN9);
    x9 = e9[8:0];
    chk("ledr9", LEDR9, x9);
    chk("pos9_range", POS9 < 4'd9, 1);
    chk("run9", RUN9, mrun);
  end

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(posedge CLK); #2; n++;
    end while (STEP !== 1'b1 && n < 400);
    if (STEP !== 1'b1) begin
      checks++; errors++;
      $display("FAIL step_timeout: got no STEP, want STEP within 400");
    end
  endtask

  task automatic wait_run(input logic v);
    int n;
    n = 0;
    while (RUN !== v && n < 50) begin
      @(posedge CLK); #2; n++;
    end
    chk("run_wait", RUN, v);
  endtask

  task automatic wait_pos(input int p, input int d);
    int  g;
    bit  hit;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      wait_step(g);
      if (int'(POS) == p && (d < 0 || int'(DIR) == d)) hit = 1;
    end
    chk("pos_reached", hit, 1);
  endtask

  int seq [19] = '{1, 2, 3, 4, 5, 6, 7, 8, 9,
                   8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  initial begin
    int g, n, p0;

    repeat (2) @(negedge CLK);
    #2;
    chk("rst_run", RUN, 0);
    chk("rst_pos", POS, 0);
    chk("rst_dir", DIR, 0);
    chk("rst_ledr", LEDR, 0);
    chk("rst_step", STEP, 0);
    @(negedge CLK) CLR = 1'b0;

    // press and hold through a full sweep
    @(negedge CLK) ONOFF_N = 1'b0;
    n = 0;
    do begin
      @(posedge CLK); #2; n++;
    end while (!RUN && n < 20);
    chk("run_latency", n, 4);
    for (int k = 0; k < 19; k++) begin
      wait_step(g);
      chk("step_gap", g, 4);
      chk("sweep_pos", POS, seq[k]);
      if (k == 8) begin
        chk("top_ledr", LEDR, 10'h200);
        chk("top_dir", DIR, 0);
      end
      if (k == 9)  chk("down_dir", DIR, 1);
      if (k == 18) chk("up_dir", DIR, 0);
    end
    chk("hold_once", RUN, 1);
    @(negedge CLK) ONOFF_N = 1'b1;

    // speed select
    @(negedge CLK) SPEED = 2'd3;
    wait_step(g);
    wait_step(g);
    chk("speed3_gap", g, 16);
    repeat (8) @(posedge CLK);
    @(negedge CLK) SPEED = 2'd0;
    wait_step(g);
    chk("speed_drop", g, 4);
    wait_step(g);
    chk("speed0_gap", g, 4);

    // wrap mode
    wait_pos(5, 1);
    @(negedge CLK) MODE = 2'b01;
    wait_step(g);
    chk("wrap_pos", POS, 6);
    chk("wrap_dir", DIR, 0);
    wait_pos(9, -1);
    wait_step(g);
    chk("wrap_zero", POS, 0);
    chk("wrap_ledr", LEDR, 10'h001);

    // bar and mirror
    @(negedge CLK) MODE = 2'b10;
    wait_pos(3, -1);
    chk("bar_ledr", LEDR, 10'h00F);
    @(negedge CLK) MODE = 2'b11;
    wait_pos(2, -1);
    chk("mirror_ledr", LEDR, 10'h084);

    // pause at 6, resume
    wait_pos(5, 0);
    @(posedge CLK);
    @(negedge CLK) ONOFF_N = 1'b0;
    repeat (3) @(negedge CLK);
    ONOFF_N = 1'b1;
    wait_run(1'b0);
    chk("pause_pos", POS, 6);
    for (int k = 0; k < 100; k++) begin
      @(posedge CLK); #2;
      chk("paused", {LEDR, POS}, {10'h000, 4'd6});
    end
    @(negedge CLK) ONOFF_N = 1'b0;
    wait_run(1'b1);
    @(negedge CLK) ONOFF_N = 1'b1;
    wait_step(g);
    chk("resume_gap", g, 4);
    chk("resume_pos", POS, 7);

    // press coincident with a step
    p0 = int'(POS);
    @(negedge CLK) ONOFF_N = 1'b0;
    wait_run(1'b0);
    chk("coinc_step", STEP, 1);
    chk("coinc_pos", POS, p0 + 1);
    @(negedge CLK) ONOFF_N = 1'b1;

    // async clear mid-scan
    repeat (3) @(negedge CLK);
    ONOFF_N = 1'b0;
    wait_run(1'b1);
    @(negedge CLK) ONOFF_N = 1'b1;
    wait_pos(7, 1);
    #1 CLR = 1'b1;
    #1;
    chk("clr_run", RUN, 0);
    chk("clr_pos", POS, 0);
    chk("clr_dir", DIR, 0);
    chk("clr_ledr", LEDR, 0);
    chk("clr_step", STEP, 0);
    @(posedge CLK);
    @(negedge CLK) CLR = 1'b0;

    // randomized phase
    for (int k = 0; k < 4000; k++) begin
      @(negedge CLK);
      if ($urandom_range(0, 39) == 0) ONOFF_N = ~ONOFF_N;
      if ($urandom_range(0, 99) == 0) MODE = 2'($urandom);
      if ($urandom_range(0, 99) == 0) SPEED = 2'($urandom);
      CLR = ($urandom_range(0, 999) == 0);
    end

    // 9-LED mirror centre
    @(negedge CLK);
    CLR = 1'b1; ONOFF_N = 1'b1;
    MODE = 2'b11; SPEED = 2'd0;
    @(negedge CLK) CLR = 1'b0;
    @(negedge CLK) ONOFF_N = 1'b0;
    wait_run(1'b1);
    n = 0;
    while (POS9 != 4'd4 && n < 100) begin
      @(posedge CLK); #2; n++;
    end
    chk("mirror9_ledr", LEDR9, 9'h010);
    @(negedge CLK) ONOFF_N = 1'b1;
    repeat (4) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
